// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit and its prediction queue.
package branch_resolve_unit_pkg;

   localparam int unsigned BRU_XLEN        = 32;
   localparam int unsigned BRU_DEPTH       = 4;
   localparam int unsigned BRU_CNT_W       = 32;
   localparam int unsigned BRU_INSTR_BYTES = 4;

   // One fetch-time prediction held in flight until its instruction resolves.
   typedef struct packed {
      logic [BRU_XLEN-1:0] pc;
      logic                pred;
      logic                taken;
      logic [BRU_XLEN-1:0] pred_pc;
   } bp_entry_t;

   // Resolution bundle returned to the fetch-stage predictor.
   typedef struct packed {
      logic                branch;
      logic                jumps;
      logic                prediction;
      logic                taken;
      logic                pc_ok;
      logic [BRU_XLEN-1:0] pc;
      logic [BRU_XLEN-1:0] target;
   } bp_resolve_t;

   // Sequential next PC of an instruction; wraps at the top of the address space.
   function automatic logic [BRU_XLEN-1:0] seq_pc(input logic [BRU_XLEN-1:0] pc);
      return pc + BRU_XLEN'(BRU_INSTR_BYTES);
   endfunction

endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// In-flight prediction queue: DEPTH-entry synchronous FIFO with push/pop/flush.
module branch_resolve_unit_fifo
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned DEPTH = BRU_DEPTH
) (
   input  logic      clk_i,
   input  logic      rsn_i,
   input  logic      push_i,
   input  bp_entry_t wdata_i,
   input  logic      pop_i,
   input  logic      flush_i,
   output bp_entry_t rdata_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   bp_entry_t         mem_q [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push;
   logic              do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rptr_q];

   // A pop frees a slot in the same cycle, so a full queue may accept a push alongside it.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Pointer and occupancy update; flush discards everything including a same-cycle push.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PTR_W'(1);
         if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (do_push && !flush_i) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: matches resolving instructions against queued
// fetch predictions, raises redirects on mispredict and reports outcomes to the predictor.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned DEPTH = BRU_DEPTH
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic                 fetch_valid_i,
   input  logic [BRU_XLEN-1:0]  fetch_pc_i,
   input  logic                 fetch_pred_i,
   input  logic                 fetch_taken_i,
   input  logic [BRU_XLEN-1:0]  fetch_pred_pc_i,
   output logic                 fetch_stall_o,
   input  logic                 ex_valid_i,
   input  logic [BRU_XLEN-1:0]  ex_pc_i,
   input  logic                 ex_branch_i,
   input  logic                 ex_jumps_i,
   input  logic [BRU_XLEN-1:0]  ex_target_i,
   output logic                 alu_branch_o,
   output logic                 alu_jumps_o,
   output logic                 alu_prediction_o,
   output logic                 alu_taken_o,
   output logic                 alu_pc_ok_o,
   output logic [BRU_XLEN-1:0]  alu_branch_pc_o,
   output logic [BRU_XLEN-1:0]  target_pc_o,
   output logic                 redirect_o,
   output logic [BRU_XLEN-1:0]  redirect_pc_o,
   output logic [BRU_CNT_W-1:0] branch_cnt_o,
   output logic [BRU_CNT_W-1:0] mispred_cnt_o
);

   bp_entry_t              push_entry;
   bp_entry_t              head;
   logic                   q_full;
   logic                   q_empty;
   logic                   head_hit;
   logic                   eff_pred;
   logic                   eff_taken;
   logic [BRU_XLEN-1:0]    eff_pred_pc;
   logic [BRU_XLEN-1:0]    fetched_next;
   logic [BRU_XLEN-1:0]    actual_next;
   logic                   mispredict;

   bp_resolve_t            res_q, res_d;
   logic                   redirect_q, redirect_d;
   logic [BRU_XLEN-1:0]    redirect_pc_q, redirect_pc_d;
   logic [BRU_CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
   logic [BRU_CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

   assign push_entry = '{pc:      fetch_pc_i,
                         pred:    fetch_pred_i,
                         taken:   fetch_taken_i,
                         pred_pc: fetch_pred_pc_i};

   branch_resolve_unit_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rsn_i   (rsn_i),
      .push_i  (fetch_valid_i),
      .wdata_i (push_entry),
      .pop_i   (ex_valid_i),
      .flush_i (mispredict),
      .rdata_o (head),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   assign fetch_stall_o = q_full;

   // Head prediction only counts when it belongs to the resolving instruction.
   always_comb begin
      head_hit     = ~q_empty & (head.pc == ex_pc_i);
      eff_pred     = head_hit & head.pred;
      eff_taken    = head_hit & head.taken;
      eff_pred_pc  = q_empty ? '0 : head.pred_pc;
      fetched_next = (eff_pred & eff_taken) ? eff_pred_pc : seq_pc(ex_pc_i);
      actual_next  = (ex_branch_i & ex_jumps_i) ? ex_target_i : seq_pc(ex_pc_i);
      mispredict   = ex_valid_i & (fetched_next != actual_next);
   end

   // Next-state for the resolution bundle, redirect and saturating counters.
   always_comb begin
      res_d         = '0;
      redirect_d    = 1'b0;
      redirect_pc_d = '0;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (ex_valid_i) begin
         res_d.branch     = ex_branch_i;
         res_d.jumps      = ex_jumps_i;
         res_d.prediction = eff_pred;
         res_d.taken      = eff_taken;
         res_d.pc_ok      = (eff_pred_pc == ex_target_i);
         res_d.pc         = ex_pc_i;
         res_d.target     = ex_target_i;
         if (ex_branch_i && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + BRU_CNT_W'(1);
         end
      end
      if (mispredict) begin
         redirect_d    = 1'b1;
         redirect_pc_d = actual_next;
         if (mispred_cnt_q != '1) begin
            mispred_cnt_d = mispred_cnt_q + BRU_CNT_W'(1);
         end
      end
   end

   // Output and counter registers.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         res_q         <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         res_q         <= res_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign alu_branch_o     = res_q.branch;
   assign alu_jumps_o      = res_q.jumps;
   assign alu_prediction_o = res_q.prediction;
   assign alu_taken_o      = res_q.taken;
   assign alu_pc_ok_o      = res_q.pc_ok;
   assign alu_branch_pc_o  = res_q.pc;
   assign target_pc_o      = res_q.target;
   assign redirect_o       = redirect_q;
   assign redirect_pc_o    = redirect_pc_q;
   assign branch_cnt_o     = branch_cnt_q;
   assign mispred_cnt_o    = mispred_cnt_q;

endmodule
